// File: rtl/vfd_grid_sequencer.sv
// vfd_grid_sequencer: per-grid BLK/LAT strobe, tri-SPI shift window and GCP pulse timing.
// Every output is registered from the next-cycle period position, so outputs line up with p.
module vfd_grid_sequencer #(
    parameter int REFRESH_DIV = 3840,
    parameter int NUM_GRIDS   = 52,
    parameter int LAT_LEN     = 5,
    parameter int SHIFT_LEN   = 288
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    output logic       BLK,
    output logic       LAT,
    output logic [5:0] GRID_NUM,
    output logic       SHIFT_EN,
    output logic [8:0] BIT_IDX,
    output logic       GCP,
    output logic       FRAME_START,
    output logic       BUSY
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_LAT  = PW'(LAT_LEN);
    localparam logic [PW-1:0] P_S0   = PW'(LAT_LEN + 2);
    localparam logic [PW-1:0] P_SE   = PW'(LAT_LEN + 2 + SHIFT_LEN);
    localparam logic [5:0]    G_LAST = 6'(NUM_GRIDS - 1);

    typedef enum logic [2:0] {IDLE, BLANK, LATCH, HOLD, SHIFT, WAIT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] p, p_n;
    logic [5:0]    grid_n;
    logic [8:0]    idx_n;
    logic          run_n, end_n;

    // EN is only sampled in IDLE and at the last cycle of a period
    always_comb begin
        end_n  = (state != IDLE) && (p == P_LAST);
        run_n  = (state == IDLE || end_n) ? EN : 1'b1;
        p_n    = (state == IDLE || end_n) ? '0 : p + 1'b1;
        grid_n = end_n ? ((GRID_NUM == G_LAST) ? 6'd0 : GRID_NUM + 6'd1) : GRID_NUM;
        state_n = !run_n ? IDLE :
                  (p_n == '0) ? BLANK :
                  (p_n <= P_LAT) ? LATCH :
                  (p_n < P_S0) ? HOLD :
                  (p_n < P_SE) ? SHIFT : WAIT;
        idx_n  = (state_n == SHIFT) ? 9'(p_n - P_S0) : 9'd0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            p           <= '0;
            GRID_NUM    <= '0;
            BLK         <= 1'b1;
            LAT         <= 1'b0;
            SHIFT_EN    <= 1'b0;
            BIT_IDX     <= '0;
            GCP         <= 1'b0;
            FRAME_START <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_n;
            p           <= p_n;
            GRID_NUM    <= grid_n;
            BLK         <= state_n inside {IDLE, BLANK, LATCH, HOLD};
            LAT         <= state_n == LATCH;
            SHIFT_EN    <= state_n == SHIFT;
            BIT_IDX     <= idx_n;
            GCP         <= (state_n == SHIFT) &&
                           (idx_n inside {9'd72, 9'd144, 9'd192, 9'd216, 9'd240, 9'd256});
            FRAME_START <= (state_n == BLANK) && (grid_n == 6'd0);
            BUSY        <= state_n != IDLE;
        end
    end
endmodule
